dpad_event_conditioner: RTL

// Front end for the d-pad code acceptor. It takes the four raw active-low d-pad

---
 rtl/dpad_event_conditioner.sv | 117 +++++++++++
 1 files changed

// File: rtl/dpad_event_conditioner.sv
// D-pad front end: per-button 2-flop synchronizer and debouncer, registered release
// pulses, priority-encoded release event and a saturating idle timeout.
module dpad_event_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16,
    parameter int TIMEOUT_BITS    = 25
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       up_,
    input  logic       down_,
    input  logic       left_,
    input  logic       right_,
    output logic [3:0] pressed,
    output logic       up_released,
    output logic       down_released,
    output logic       left_released,
    output logic       right_released,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       event_multi,
    output logic       idle_timeout
);

    logic [3:0] raw;
    logic [3:0] fall;
    logic [3:0] rel;
    logic [1:0] code_next;
    logic [TIMEOUT_BITS-1:0] idle_reg;

    assign raw = {right_, left_, down_, up_};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            db_d_reg;
            logic            rel_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            sampled;

            assign sampled = ~sync2_reg;

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    db_reg    <= 1'b0;
                    db_d_reg  <= 1'b0;
                    rel_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    db_d_reg  <= db_reg;
                    rel_reg   <= db_d_reg & ~db_reg;
                    if (sampled != db_reg) begin
                        if (cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                            db_reg  <= sampled;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + DB_W'(1);
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            // Falling edge of the debounced level, one cycle late so the pulse
            // and the event outputs are registered together.
            assign fall[gi]    = db_d_reg & ~db_reg;
            assign pressed[gi] = db_reg;
            assign rel[gi]     = rel_reg;
        end
    endgenerate

    assign up_released    = rel[0];
    assign down_released  = rel[1];
    assign left_released  = rel[2];
    assign right_released = rel[3];

    always_comb begin
        code_next = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (fall[i]) code_next = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            event_valid <= 1'b0;
            event_code  <= 2'd0;
            event_multi <= 1'b0;
        end else begin
            event_valid <= |fall;
            event_multi <= |(fall & (fall - 4'd1));
            if (|fall) event_code <= code_next;
        end
    end

    // Only releases restart the idle count; presses leave it running.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            idle_reg <= '0;
        end else if (event_valid) begin
            idle_reg <= '0;
        end else if (!(&idle_reg)) begin
            idle_reg <= idle_reg + TIMEOUT_BITS'(1);
        end
    end

    assign idle_timeout = &idle_reg;

endmodule
